// File: rtl/inst_cache_pkg.sv
// Shared types and helpers for the instruction cache: FSM encoding, bus widths
// and the word-alignment helper used when latching refill addresses.
package inst_cache_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

    function automatic logic [INST_ADDR_W-1:0] word_addr(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage for the instruction cache: valid bits (resettable), tags and
// data (not reset). Asynchronous read by index, one synchronous write port.
module icache_array #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-latency hits,
// a req/ack refill port to slow instruction memory, and hit/miss counters.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_ce_i,
    input  logic [31:0]   rom_addr_i,
    output logic [31:0]   rom_data_o,
    output logic          stallreq_o,
    input  logic          flush_i,
    output logic          mem_req_o,
    output logic [31:0]   mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [31:0]   mem_rdata_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output icache_state_e dbg_state_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 32 - IDX_W - 2;

    icache_state_e    state_q;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic             drop_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             lookup;
    logic             hit;
    logic             miss;
    logic             fill_we;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^rom_addr_i[1:0];

    // Lookups only happen in IDLE; during REFILL the core's address is ignored.
    assign lookup  = !rst && (state_q == ICACHE_IDLE) && rom_ce_i;
    assign hit     = lookup && line_valid && (line_tag == rom_addr_i[31:IDX_W+2]);
    assign miss    = lookup && !hit;
    // A flush seen at any point of the refill (including the ack cycle) drops the fill.
    assign fill_we = !rst && (state_q == ICACHE_REFILL) && mem_ack_i && !drop_q && !flush_i;

    icache_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush_i),
        .rd_idx_i   (rom_addr_i[IDX_W+1:2]),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .we_i       (fill_we),
        .wr_idx_i   (mem_addr_q[IDX_W+1:2]),
        .wr_tag_i   (mem_addr_q[31:IDX_W+2]),
        .wr_data_i  (mem_rdata_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ICACHE_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= ZERO_WORD;
            drop_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (hit) begin
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end else if (miss) begin
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        mem_addr_q <= word_addr(rom_addr_i);
                        mem_req_q  <= 1'b1;
                        drop_q     <= 1'b0;
                        state_q    <= ICACHE_REFILL;
                    end
                end
                ICACHE_REFILL: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        state_q   <= ICACHE_IDLE;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= ICACHE_IDLE;
            endcase
        end
    end

    assign stallreq_o  = !rst && ((state_q == ICACHE_REFILL) || miss);
    assign rom_data_o  = hit ? line_data : ZERO_WORD;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a per-cycle vector table for the basic
// miss/refill/hit/conflict flow, then hand-written flush, reset and fill sequences.
module tb_inst_cache;
    import inst_cache_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_ce_i;
    logic [31:0]   rom_addr_i;
    logic [31:0]   rom_data_o;
    logic          stallreq_o;
    logic          flush_i;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
    icache_state_e dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    vec_t tbl [14];

    inst_cache dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce_i    (rom_ce_i),
        .rom_addr_i  (rom_addr_i),
        .rom_data_o  (rom_data_o),
        .stallreq_o  (stallreq_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(logic ce, logic [31:0] addr, logic ack, logic [31:0] rdata,
                                logic [31:0] e_data, logic e_stall, logic e_req,
                                logic [31:0] e_maddr, logic [31:0] e_hit, logic [31:0] e_miss);
        vec_t v;
        v.ce = ce; v.addr = addr; v.ack = ack; v.rdata = rdata;
        v.e_data = e_data; v.e_stall = e_stall; v.e_req = e_req;
        v.e_maddr = e_maddr; v.e_hit = e_hit; v.e_miss = e_miss;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name);
        tick();
        rom_ce_i = 1'b0; mem_ack_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check({name, "_hit_cnt"}, hit_cnt_o, exp_hit);
        check({name, "_miss_cnt"}, miss_cnt_o, exp_miss);
    endtask

    // Miss cycle, `delay` REFILL cycles without ack (address wiggled), then ack cycle.
    task automatic refill(input logic [31:0] addr, input logic [31:0] data, input int delay);
        tick();
        rom_ce_i = 1'b1; rom_addr_i = addr; mem_ack_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("miss_stall", 32'(stallreq_o), 32'd1);
        check("miss_req", 32'(mem_req_o), 32'd0);
        exp_miss++;
        for (int d = 0; d < delay; d++) begin
            tick();
            rom_addr_i = addr ^ 32'h0000_0040;
            mem_ack_i  = 1'b0;
            @(negedge clk);
            check("wait_req", 32'(mem_req_o), 32'd1);
            check("wait_maddr", mem_addr_o, {addr[31:2], 2'b00});
        end
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = data;
        @(negedge clk);
        check("ack_req", 32'(mem_req_o), 32'd1);
        check("ack_stall", 32'(stallreq_o), 32'd1);
    endtask

    task automatic lookup_hit(input logic [31:0] addr, input logic [31:0] exp_data);
        tick();
        rom_ce_i = 1'b1; rom_addr_i = addr; mem_ack_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("hit_stall", 32'(stallreq_o), 32'd0);
        check("hit_data", rom_data_o, exp_data);
        check("hit_req", 32'(mem_req_o), 32'd0);
        exp_hit++;
    endtask

    initial begin
        // Basic flow, ce=0 with ack noise, and the idx-0 conflict between 0x0 and 0x40.
        tbl[0]  = mk(1, 32'h00, 0, 32'h0,        32'h0,        1, 0, 32'h00, 0, 0);
        tbl[1]  = mk(1, 32'h00, 1, 32'h34011100, 32'h0,        1, 1, 32'h00, 0, 1);
        tbl[2]  = mk(1, 32'h00, 0, 32'h0,        32'h34011100, 0, 0, 32'h00, 0, 1);
        tbl[3]  = mk(0, 32'h00, 0, 32'h0,        32'h0,        0, 0, 32'h00, 1, 1);
        tbl[4]  = mk(0, 32'h40, 1, 32'hFFFFFFFF, 32'h0,        0, 0, 32'h00, 1, 1);
        tbl[5]  = mk(0, 32'h04, 1, 32'h12345678, 32'h0,        0, 0, 32'h00, 1, 1);
        tbl[6]  = mk(1, 32'h40, 0, 32'h0,        32'h0,        1, 0, 32'h00, 1, 1);
        tbl[7]  = mk(0, 32'h7C, 0, 32'h0,        32'h0,        1, 1, 32'h40, 1, 2);
        tbl[8]  = mk(1, 32'h00, 1, 32'h11111111, 32'h0,        1, 1, 32'h40, 1, 2);
        tbl[9]  = mk(1, 32'h40, 0, 32'h0,        32'h11111111, 0, 0, 32'h40, 1, 2);
        tbl[10] = mk(1, 32'h00, 0, 32'h0,        32'h0,        1, 0, 32'h40, 2, 2);
        tbl[11] = mk(1, 32'h00, 1, 32'h34011100, 32'h0,        1, 1, 32'h00, 2, 3);
        tbl[12] = mk(1, 32'h00, 0, 32'h0,        32'h34011100, 0, 0, 32'h00, 2, 3);
        tbl[13] = mk(0, 32'h00, 0, 32'h0,        32'h0,        0, 0, 32'h00, 3, 3);

        rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = 32'h0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_maddr", mem_addr_o, 32'h0);
        check("rst_data", rom_data_o, 32'h0);
        check("rst_hit_cnt", hit_cnt_o, 32'h0);
        check("rst_miss_cnt", miss_cnt_o, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ICACHE_IDLE));

        for (int i = 0; i < 14; i++) begin
            tick();
            rom_ce_i = tbl[i].ce; rom_addr_i = tbl[i].addr;
            mem_ack_i = tbl[i].ack; mem_rdata_i = tbl[i].rdata; flush_i = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_data", i), rom_data_o, tbl[i].e_data);
            check($sformatf("vec%0d_stall", i), 32'(stallreq_o), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d_req", i), 32'(mem_req_o), 32'(tbl[i].e_req));
            check($sformatf("vec%0d_maddr", i), mem_addr_o, tbl[i].e_maddr);
            check($sformatf("vec%0d_hit", i), hit_cnt_o, tbl[i].e_hit);
            check($sformatf("vec%0d_miss", i), miss_cnt_o, tbl[i].e_miss);
        end
        exp_hit  = 32'd3;
        exp_miss = 32'd3;

        // Flush in IDLE: the lookup in the flush cycle still sees the old line.
        tick();
        rom_ce_i = 1'b1; rom_addr_i = 32'h0; flush_i = 1'b1; mem_ack_i = 1'b0;
        @(negedge clk);
        check("flush_cycle_stall", 32'(stallreq_o), 32'd0);
        check("flush_cycle_data", rom_data_o, 32'h34011100);
        exp_hit++;

        // Sequential fill of all 16 lines, then a second pass of pure hits.
        for (int i = 0; i < 16; i++) begin
            refill(32'(i * 4), 32'hA000_0000 + 32'(i), 1);
            exp_q.push_back(32'hA000_0000 + 32'(i));
        end
        for (int i = 0; i < 16; i++) begin
            lookup_hit(32'(i * 4), exp_q.pop_front());
        end
        check_counters("seq");

        // Flush while a refill of 0x8 is outstanding; the late ack must not install.
        tick();
        rom_ce_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; rom_ce_i = 1'b1; rom_addr_i = 32'h8;
        @(negedge clk);
        check("f4_miss_stall", 32'(stallreq_o), 32'd1);
        exp_miss++;
        tick();
        rom_ce_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        check("f4_req", 32'(mem_req_o), 32'd1);
        check("f4_maddr", mem_addr_o, 32'h8);
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        check("f4_ack_req", 32'(mem_req_o), 32'd1);
        refill(32'h8, 32'h0808_0808, 0);
        lookup_hit(32'h8, 32'h0808_0808);
        check_counters("flush_refill");

        // Flush coinciding with the ack cycle.
        tick();
        rom_ce_i = 1'b1; rom_addr_i = 32'hC; mem_ack_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("fa_miss_stall", 32'(stallreq_o), 32'd1);
        exp_miss++;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; flush_i = 1'b1;
        @(negedge clk);
        check("fa_req", 32'(mem_req_o), 32'd1);
        refill(32'hC, 32'h0C0C_0C0C, 0);
        lookup_hit(32'hC, 32'h0C0C_0C0C);
        check_counters("flush_ack");

        // Reset in the middle of a refill: abandoned, later ack ignored.
        tick();
        rom_ce_i = 1'b1; rom_addr_i = 32'h10; mem_ack_i = 1'b0; flush_i = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rr_state_before", 32'(dbg_state), 32'(ICACHE_REFILL));
        tick();
        rst = 1'b0; rom_ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(negedge clk);
        check("rr_req", 32'(mem_req_o), 32'd0);
        check("rr_stall", 32'(stallreq_o), 32'd0);
        check("rr_hit_cnt", hit_cnt_o, 32'd0);
        check("rr_miss_cnt", miss_cnt_o, 32'd0);
        check("rr_state", 32'(dbg_state), 32'(ICACHE_IDLE));
        exp_hit  = 32'd0;
        exp_miss = 32'd0;
        refill(32'h10, 32'h1010_1010, 0);
        lookup_hit(32'h10, 32'h1010_1010);
        check_counters("reset_refill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
